enbuyuk_bulucu: RTL and testbench
=================================

ENBUYUK_BULUCU -- requirements
Module: enbuyuk_bulucu

Interface
REQ-001 Parameter: N, 8, buffer depth (max number of 3-bit weights per job), 2..8.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 baslat  input  1  start pulse; sampled only in state BOS.
REQ-005 adet  input  4  number of weights for the job; sampled with baslat.
REQ-006 veri  input  3  unsigned weight word.
REQ-007 veri_gecerli  input  1  veri valid.
REQ-008 veri_hazir  output  1  block accepts veri this cycle.
REQ-009 en_buyuk  output  3  maximum weight of the job.
REQ-010 en_buyuk_idx  output  3  arrival index (0-based) of the maximum.
REQ-011 bos_kume  output  1  job had adet==0 or adet>N.
REQ-012 sonuc_gecerli  output  1  result valid.
REQ-013 sonuc_al  input  1  consumer acknowledges result.
REQ-014 mesgul  output  1  high in every state except BOS.

Function
REQ-015 FSM SHALL have states BOS (idle), YUKLE (load), TARA (scan), SONUC (result).
REQ-016 BOS: baslat=1 and 1<=adet<=N -> YUKLE, adet latched; baslat=1 and adet invalid -> SONUC with bos_kume=1, en_buyuk=0, en_buyuk_idx=0.
REQ-017 baslat outside BOS SHALL be ignored; latched adet SHALL not change mid-job.
REQ-018 YUKLE: veri_hazir=1; each cycle with veri_gecerli=1 writes veri to buffer[k], k increments from 0.
REQ-019 After write of word adet-1, veri_hazir SHALL drop the next cycle and FSM -> TARA; no extra word accepted.
REQ-020 TARA SHALL use exactly one shared 3-bit unsigned >= comparator, one comparison per cycle.
REQ-021 TARA entry: running max=buffer[0], idx=0, pointer=1; each cycle compares buffer[pointer] against running max.
REQ-022 Replacement only when candidate strictly greater (not max>=candidate); ties keep lowest index.
REQ-023 TARA duration SHALL be max(adet-1,1) cycles; adet=1 gives one idle scan cycle, result buffer[0], idx 0.
REQ-024 SONUC: sonuc_gecerli=1; en_buyuk, en_buyuk_idx, bos_kume stable until handshake.
REQ-025 sonuc_gecerli&sonuc_al -> BOS next cycle; sonuc_gecerli drops; outputs hold last values.
REQ-026 Latency: last accepted word to sonuc_gecerli = max(adet-1,1)+1 cycles.
REQ-027 sonuc_al outside SONUC SHALL be ignored; veri_gecerli outside YUKLE SHALL be ignored.

Reset
REQ-028 rst_n=0 SHALL immediately force BOS and clear veri_hazir, sonuc_gecerli, mesgul, bos_kume, en_buyuk, en_buyuk_idx, write counter and pointer, in any state.
REQ-029 Buffer contents need not be cleared; a new job SHALL never read entries not written in that job.
REQ-030 First baslat SHALL be honoured on the first rising edge after rst_n rises.

Configuration
REQ-031 Macro ENKUCUK_CIKIS_EN: when defined, add outputs en_kucuk (3) and en_kucuk_idx (3), computed in the same TARA pass with a second comparator, ties lowest index, reset 0, same handshake as REQ-024/025.
REQ-032 Without ENKUCUK_CIKIS_EN: those ports and the second comparator SHALL be absent; all other behaviour identical.

Verification
REQ-033 adet=5, words 3,6,2,6,1 -> en_buyuk=6, idx=1, sonuc_gecerli 5 cycles after last word (with macro: en_kucuk=1, idx=4).
REQ-034 adet=1, word 4 -> en_buyuk=4, idx=0, sonuc_gecerli 2 cycles after the word.
REQ-035 adet=0 then adet=9 -> each gives sonuc_gecerli next cycle, bos_kume=1, veri_hazir never asserted.
REQ-036 adet=8, words 0..7 with veri_gecerli gapped every other cycle, 2 extra valid words after -> en_buyuk=7, idx=7, extra words not accepted.
REQ-037 rst_n low during TARA of adet=6 job -> all outputs 0, BOS; next job adet=2 words 5,5 -> en_buyuk=5, idx=0.
REQ-038 sonuc_al held low 10 cycles in SONUC, baslat pulsed meanwhile -> outputs stable, baslat ignored, BOS one cycle after sonuc_al.

Source files
------------

// File: rtl/enbuyuk_bulucu.sv
// enbuyuk_bulucu: buffers up to N 3-bit weights per job, then scans them once to find the largest and its first index.
// Define ENKUCUK_CIKIS_EN to also report the smallest weight and its first index from the same scan.
module enbuyuk_bulucu #(
  parameter int N = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       baslat,
  input  logic [3:0] adet,
  input  logic [2:0] veri,
  input  logic       veri_gecerli,
  output logic       veri_hazir,
  output logic [2:0] en_buyuk,
  output logic [2:0] en_buyuk_idx,
  output logic       bos_kume,
  output logic       sonuc_gecerli,
  input  logic       sonuc_al,
`ifdef ENKUCUK_CIKIS_EN
  output logic [2:0] en_kucuk,
  output logic [2:0] en_kucuk_idx,
`endif
  output logic       mesgul
);
  typedef enum logic [1:0] {BOS, YUKLE, TARA, SONUC} durum_t;
  durum_t durum, sonraki;
  logic [3:0] adet_r, k;
  logic [2:0] ptr, mx, mi;
  logic [2:0] tampon [N];
  logic [2:0] aday, ilk;
  logic gecerli_adet, son_yaz, son_tara, karsilastir, buyuk;
  assign gecerli_adet = adet != 4'd0 && adet <= 4'(N);
  assign son_yaz = veri_gecerli && k == adet_r - 4'd1;
  assign aday = tampon[ptr];
  assign ilk = k == 4'd0 ? veri : tampon[0];
  // A scan step with ptr beyond the job length is the idle cycle of a one-word job.
  assign karsilastir = {1'b0, ptr} < adet_r;
  assign buyuk = karsilastir && !(mx >= aday);
  assign son_tara = {1'b0, ptr} + 4'd1 >= adet_r;
  assign veri_hazir = durum == YUKLE;
  assign sonuc_gecerli = durum == SONUC;
  assign mesgul = durum != BOS;
`ifdef ENKUCUK_CIKIS_EN
  logic [2:0] mn, ni;
  logic kucuk;
  assign kucuk = karsilastir && !(aday >= mn);
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) durum <= BOS;
    else durum <= sonraki;
  always_comb begin
    sonraki = durum;
    unique case (durum)
      BOS:   sonraki = baslat ? (gecerli_adet ? YUKLE : SONUC) : BOS;
      YUKLE: sonraki = son_yaz ? TARA : YUKLE;
      TARA:  sonraki = son_tara ? SONUC : TARA;
      SONUC: sonraki = sonuc_al ? BOS : SONUC;
    endcase
  end
  always_ff @(posedge clk)
    if (durum == YUKLE && veri_gecerli) tampon[k[2:0]] <= veri;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      adet_r <= '0;
      k <= '0;
      ptr <= '0;
      mx <= '0;
      mi <= '0;
      en_buyuk <= '0;
      en_buyuk_idx <= '0;
      bos_kume <= 1'b0;
`ifdef ENKUCUK_CIKIS_EN
      mn <= '0;
      ni <= '0;
      en_kucuk <= '0;
      en_kucuk_idx <= '0;
`endif
    end else begin
      if (durum == BOS && baslat) begin
        adet_r <= adet;
        k <= '0;
        if (!gecerli_adet) begin
          bos_kume <= 1'b1;
          en_buyuk <= '0;
          en_buyuk_idx <= '0;
`ifdef ENKUCUK_CIKIS_EN
          en_kucuk <= '0;
          en_kucuk_idx <= '0;
`endif
        end
      end
      if (durum == YUKLE && veri_gecerli) begin
        k <= k + 4'd1;
        if (son_yaz) begin
          mx <= ilk;
          mi <= '0;
          ptr <= 3'd1;
`ifdef ENKUCUK_CIKIS_EN
          mn <= ilk;
          ni <= '0;
`endif
        end
      end
      if (durum == TARA) begin
        ptr <= ptr + 3'd1;
        mx <= buyuk ? aday : mx;
        mi <= buyuk ? ptr : mi;
`ifdef ENKUCUK_CIKIS_EN
        mn <= kucuk ? aday : mn;
        ni <= kucuk ? ptr : ni;
`endif
        if (son_tara) begin
          en_buyuk <= buyuk ? aday : mx;
          en_buyuk_idx <= buyuk ? ptr : mi;
          bos_kume <= 1'b0;
`ifdef ENKUCUK_CIKIS_EN
          en_kucuk <= kucuk ? aday : mn;
          en_kucuk_idx <= kucuk ? ptr : ni;
`endif
        end
      end
    end
endmodule

// File: tb/tb_enbuyuk_bulucu.sv
// tb_enbuyuk_bulucu: directed jobs checked against a queue-based job model every cycle plus hand-computed literals.
module tb_enbuyuk_bulucu;
  localparam int N = 8;
  typedef logic [2:0] kelime_t [8];
  logic clk = 0, rst_n = 0, baslat = 0, veri_gecerli = 0, sonuc_al = 0;
  logic [3:0] adet = '0;
  logic [2:0] veri = '0;
  logic veri_hazir, bos_kume, sonuc_gecerli, mesgul;
  logic [2:0] en_buyuk, en_buyuk_idx;
`ifdef ENKUCUK_CIKIS_EN
  logic [2:0] en_kucuk, en_kucuk_idx;
`endif
  int pass_cnt = 0, tot_cnt = 0, n;
  bit chk_on = 0;
  int m_ph = 0, m_need = 0, m_wait = 0, m_max = 0, m_idx = 0, m_bos = 0, m_min = 0, m_nidx = 0;
  int m_q[$];
  always #5 clk = ~clk;
  enbuyuk_bulucu #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .baslat(baslat), .adet(adet), .veri(veri),
    .veri_gecerli(veri_gecerli), .veri_hazir(veri_hazir), .en_buyuk(en_buyuk),
    .en_buyuk_idx(en_buyuk_idx), .bos_kume(bos_kume), .sonuc_gecerli(sonuc_gecerli),
    .sonuc_al(sonuc_al),
`ifdef ENKUCUK_CIKIS_EN
    .en_kucuk(en_kucuk), .en_kucuk_idx(en_kucuk_idx),
`endif
    .mesgul(mesgul)
  );
  task automatic chk(input string nm, input int act, input int exp);
    tot_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
  endtask
  // Job model: phase 0 idle, 1 collecting words, 2 scanning (cycle countdown), 3 result.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_ph = 0; m_max = 0; m_idx = 0; m_bos = 0; m_min = 0; m_nidx = 0;
    end else begin
      case (m_ph)
        0: if (baslat) begin
          if (adet >= 1 && adet <= N) begin
            m_ph = 1; m_need = int'(adet); m_q.delete();
          end else begin
            m_ph = 3; m_max = 0; m_idx = 0; m_min = 0; m_nidx = 0; m_bos = 1;
          end
        end
        1: if (veri_gecerli) begin
          m_q.push_back(int'(veri));
          if (m_q.size() == m_need) begin
            m_ph = 2; m_wait = m_need > 1 ? m_need - 1 : 1;
          end
        end
        2: begin
          m_wait--;
          if (m_wait == 0) begin
            m_max = m_q[0]; m_idx = 0; m_min = m_q[0]; m_nidx = 0;
            for (int i = 1; i < m_q.size(); i++) begin
              if (m_q[i] > m_max) begin m_max = m_q[i]; m_idx = i; end
              if (m_q[i] < m_min) begin m_min = m_q[i]; m_nidx = i; end
            end
            m_bos = 0; m_ph = 3;
          end
        end
        default: if (sonuc_al) m_ph = 0;
      endcase
    end
  always @(negedge clk)
    if (chk_on) begin
      chk("m_hazir", veri_hazir, m_ph == 1);
      chk("m_gecerli", sonuc_gecerli, m_ph == 3);
      chk("m_mesgul", mesgul, m_ph != 0);
      chk("m_max", en_buyuk, m_max);
      chk("m_idx", en_buyuk_idx, m_idx);
      chk("m_bos", bos_kume, m_bos);
`ifdef ENKUCUK_CIKIS_EN
      chk("m_min", en_kucuk, m_min);
      chk("m_nidx", en_kucuk_idx, m_nidx);
`endif
    end
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic basla(input logic [3:0] a);
    baslat = 1; adet = a;
    step();
    baslat = 0;
  endtask
  task automatic gonder(input kelime_t w, input int cnt, input bit gap);
    for (int i = 0; i < cnt; i++) begin
      veri = w[i]; veri_gecerli = 1;
      step();
      veri_gecerli = 0;
      if (gap && i < cnt - 1) step();
    end
  endtask
  task automatic bekle(output int c);
    c = 0;
    while (!sonuc_gecerli && c < 40) begin step(); c++; end
    if (!sonuc_gecerli) chk("timeout", 0, 1);
  endtask
  task automatic al();
    sonuc_al = 1;
    step();
    sonuc_al = 0;
    chk("al_mesgul", mesgul, 0);
    chk("al_gecerli", sonuc_gecerli, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    step(); step();
    chk("rst_mesgul", mesgul, 0);
    chk("rst_hazir", veri_hazir, 0);
    chk("rst_gecerli", sonuc_gecerli, 0);
    chk("rst_max", en_buyuk, 0);
    chk("rst_idx", en_buyuk_idx, 0);
    chk("rst_bos", bos_kume, 0);
    rst_n = 1; chk_on = 1;
    basla(5);
    chk("j1_hazir", veri_hazir, 1);
    gonder('{3, 6, 2, 6, 1, 0, 0, 0}, 5, 0);
    bekle(n);
    chk("j1_lat", n + 1, 5);
    chk("j1_max", en_buyuk, 6);
    chk("j1_idx", en_buyuk_idx, 1);
`ifdef ENKUCUK_CIKIS_EN
    chk("j1_min", en_kucuk, 1);
    chk("j1_nidx", en_kucuk_idx, 4);
`endif
    al();
    basla(1);
    gonder('{4, 0, 0, 0, 0, 0, 0, 0}, 1, 0);
    bekle(n);
    chk("j2_lat", n + 1, 2);
    chk("j2_max", en_buyuk, 4);
    chk("j2_idx", en_buyuk_idx, 0);
    al();
    basla(0);
    chk("e0_gecerli", sonuc_gecerli, 1);
    chk("e0_bos", bos_kume, 1);
    chk("e0_max", en_buyuk, 0);
    chk("e0_hazir", veri_hazir, 0);
    al();
    basla(9);
    chk("e9_gecerli", sonuc_gecerli, 1);
    chk("e9_bos", bos_kume, 1);
    chk("e9_hazir", veri_hazir, 0);
    al();
    basla(8);
    gonder('{0, 1, 2, 3, 4, 5, 6, 7}, 8, 1);
    veri = 3; veri_gecerli = 1;
    step();
    chk("x_hazir", veri_hazir, 0);
    step();
    veri_gecerli = 0;
    bekle(n);
    chk("j3_max", en_buyuk, 7);
    chk("j3_idx", en_buyuk_idx, 7);
    chk("j3_bos", bos_kume, 0);
    al();
    basla(6);
    gonder('{1, 2, 3, 4, 5, 6, 0, 0}, 6, 0);
    step();
    rst_n = 0;
    #1;
    chk("r_mesgul", mesgul, 0);
    chk("r_hazir", veri_hazir, 0);
    chk("r_gecerli", sonuc_gecerli, 0);
    chk("r_max", en_buyuk, 0);
    chk("r_idx", en_buyuk_idx, 0);
    chk("r_bos", bos_kume, 0);
    step();
    rst_n = 1;
    basla(2);
    gonder('{5, 5, 0, 0, 0, 0, 0, 0}, 2, 0);
    bekle(n);
    chk("j4_max", en_buyuk, 5);
    chk("j4_idx", en_buyuk_idx, 0);
    al();
    basla(3);
    gonder('{2, 7, 7, 0, 0, 0, 0, 0}, 3, 0);
    bekle(n);
    for (int i = 0; i < 10; i++) begin
      baslat = i == 3; adet = 4'd2;
      step();
      chk("h_gecerli", sonuc_gecerli, 1);
      chk("h_max", en_buyuk, 7);
      chk("h_idx", en_buyuk_idx, 1);
    end
    baslat = 0;
    al();
    step();
    chk("h_bos_kaldi", mesgul, 0);
    chk("h_max_tut", en_buyuk, 7);
    step();
    chk_on = 0;
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
